kv_request_arbiter: RTL and testbench
=====================================

KV_REQUEST_ARBITER -- requirements
Module: kv_request_arbiter

Interface
REQ-001 Parameter RAM_WIDTH, 32, key/value/address width; SHALL match the key-value store.
REQ-002 Parameter NUM_REQ, 4, number of requesters (2..8).
REQ-003 Parameter OP_LATENCY, 8, store cycles from issue to valid updated_value (>=1).
REQ-004 Ports SHALL be:
  clock  in  1  single clock; all state on rising edge.
  reset_n  in  1  asynchronous, active-low reset.
  req_valid  in  NUM_REQ  per-requester command valid.
  req_ready  out  NUM_REQ  one-hot accept.
  req_signal  in  2*NUM_REQ  opcode: 0 search, 1 insert, 2 transact, 3 reserved.
  req_key  in  RAM_WIDTH*NUM_REQ  key.
  req_value  in  RAM_WIDTH*NUM_REQ  insert value or transact amount.
  req_transact_kind  in  NUM_REQ  transact direction.
  ram_enable, write_enable  out  1 each  store enables.
  key, value, transact_value  out  RAM_WIDTH each  store operands.
  signal  out  2  store opcode.
  transact_kind  out  1  store transact direction.
  updated_value, value_addr  in  RAM_WIDTH each  store results.
  rsp_valid  out  1 / rsp_ready  in  1  response handshake.
  rsp_id  out  clog2(NUM_REQ)  granted requester index.
  rsp_data, rsp_addr  out  RAM_WIDTH each  captured updated_value, value_addr.
  rsp_error  out  1  reserved opcode rejected.
  busy  out  1  high whenever state != IDLE.

Function
REQ-005 FSM states IDLE, ISSUE, WAIT, RESP; exactly one command in flight.
REQ-006 IDLE: if any req_valid, grant one requester; req_ready[g] combinational, high only in IDLE for the grant; on accept capture opcode/key/value/kind/index.
REQ-007 Accept with opcode 3: no store access; go RESP with rsp_error=1, rsp_data=rsp_addr=0 (rsp_valid at A+1).
REQ-008 Otherwise IDLE->ISSUE (cycle A+1): ram_enable=1; write_enable=1 for opcodes 1/2, 0 for search; operands driven from capture registers.
REQ-009 WAIT lasts exactly OP_LATENCY cycles (A+2..A+1+OP_LATENCY); operands and ram_enable held stable; counter width clog2(OP_LATENCY+1).
REQ-010 Last WAIT cycle samples updated_value/value_addr into rsp_data/rsp_addr; rsp_valid first high at A+2+OP_LATENCY.
REQ-011 RESP: rsp_valid, rsp_id, rsp_data, rsp_addr, rsp_error held stable until rsp_valid&rsp_ready; then IDLE; no req_ready while RESP.
REQ-012 IDLE and RESP: ram_enable=write_enable=0; other store operands hold last issued values.
REQ-013 Round-robin: search from rr_ptr upward with wrap; on grant g, rr_ptr = (g+1) mod NUM_REQ.
REQ-014 req_valid dropped before grant: ignored, no side effect; simultaneous valids resolved solely by REQ-013/REQ-018.

Reset
REQ-015 reset_n low SHALL immediately force IDLE, rr_ptr=0, counter=0 and every output to 0.
REQ-016 Reset mid-ISSUE/WAIT/RESP SHALL abort the command silently; no response later; next accept behaves as from power-up.

Configuration
REQ-017 Macro KV_ARB_FIXED_PRIO_EN undefined: round-robin per REQ-013.
REQ-018 KV_ARB_FIXED_PRIO_EN defined: lowest-index valid requester always wins; rr_ptr logic compiled out.

Structure
REQ-019 Package kv_store_pkg SHALL hold opcode constants (OP_SEARCH, OP_INSERT, OP_TRANSACT, OP_RSVD), FSM state encoding, default RAM_WIDTH.
REQ-020 Sub-module kv_rr_arbiter: combinational rotate-priority pick, inputs req vector + rr_ptr, output one-hot grant.

Verification (OP_LATENCY=8, store model)
REQ-021 Req0 search key=249, model returns 500 -> A+1 ram_enable=1, write_enable=0, key=249; rsp_valid at A+10, rsp_id=0, rsp_data=500.
REQ-022 Req2 insert key=524 value=3423 -> signal=1, write_enable=1, value=3423 stable A+1..A+9; rsp_id=2.
REQ-023 All four req_valid held -> grant order 0,1,2,3,0; with KV_ARB_FIXED_PRIO_EN -> 0,0,0.
REQ-024 rsp_ready low 5 cycles -> rsp_* stable, req_ready all 0 until handshake.
REQ-025 Req1 opcode 3 -> ram_enable never high; rsp_valid at A+1, rsp_error=1, rsp_data=0.
REQ-026 reset_n pulsed during WAIT -> ram_enable 0 same cycle, no rsp_valid; following search served per REQ-021 timing.

Source files
------------

// File: rtl/kv_store_pkg.sv
// kv_store_pkg: shared opcodes, FSM states and default width for the kv request arbiter
package kv_store_pkg;
  localparam int RAM_WIDTH_DEF = 32;
  localparam logic [1:0] OP_SEARCH   = 2'd0;
  localparam logic [1:0] OP_INSERT   = 2'd1;
  localparam logic [1:0] OP_TRANSACT = 2'd2;
  localparam logic [1:0] OP_RSVD     = 2'd3;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;
endpackage

// File: rtl/kv_rr_arbiter.sv
// kv_rr_arbiter: combinational rotate-priority pick, first set request at or above i_ptr (wrapping)
// Ports: i_req request vector, i_ptr priority start index, o_grant one-hot grant (0 when no request)
module kv_rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         i_req,
  input  logic [$clog2(N)-1:0] i_ptr,
  output logic [N-1:0]         o_grant
);
  // Scan from farthest to nearest offset so the nearest requester above i_ptr wins.
  always_comb begin
    o_grant = '0;
    for (int i = N - 1; i >= 0; i--)
      if (i_req[(int'(i_ptr) + i) % N]) o_grant = N'(1) << ((int'(i_ptr) + i) % N);
  end
endmodule

// File: rtl/kv_request_arbiter.sv
// kv_request_arbiter: serialises NUM_REQ command streams onto one key-value store, one command in flight
// Ports: clock/reset_n (async active-low); req_* per-requester command bus with one-hot req_ready;
//   ram_enable/write_enable/key/value/transact_value/signal/transact_kind drive the store,
//   updated_value/value_addr are its results; rsp_* is the response handshake; busy = not IDLE.
// Build option: KV_ARB_FIXED_PRIO_EN selects fixed lowest-index priority instead of round-robin.
module kv_request_arbiter
  import kv_store_pkg::*;
#(
  parameter int RAM_WIDTH  = RAM_WIDTH_DEF,
  parameter int NUM_REQ    = 4,
  parameter int OP_LATENCY = 8
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [2*NUM_REQ-1:0]         req_signal,
  input  logic [RAM_WIDTH*NUM_REQ-1:0] req_key,
  input  logic [RAM_WIDTH*NUM_REQ-1:0] req_value,
  input  logic [NUM_REQ-1:0]           req_transact_kind,
  output logic                         ram_enable,
  output logic                         write_enable,
  output logic [RAM_WIDTH-1:0]         key,
  output logic [RAM_WIDTH-1:0]         value,
  output logic [RAM_WIDTH-1:0]         transact_value,
  output logic [1:0]                   signal,
  output logic                         transact_kind,
  input  logic [RAM_WIDTH-1:0]         updated_value,
  input  logic [RAM_WIDTH-1:0]         value_addr,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0]   rsp_id,
  output logic [RAM_WIDTH-1:0]         rsp_data,
  output logic [RAM_WIDTH-1:0]         rsp_addr,
  output logic                         rsp_error,
  output logic                         busy
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(OP_LATENCY + 1);
  state_t               r_state;
  logic [CW-1:0]        r_cnt;
  logic [IW-1:0]        r_idx, r_rsp_id, w_idx, w_ptr;
  logic [NUM_REQ-1:0]   w_grant;
  logic                 w_accept;
  logic [1:0]           w_sig, r_signal;
  logic [RAM_WIDTH-1:0] w_key, w_val;
  logic [RAM_WIDTH-1:0] r_key, r_value, r_transact_value, r_rsp_data, r_rsp_addr;
  logic                 r_ram_enable, r_write_enable, r_transact_kind, r_rsp_valid, r_rsp_error;

  kv_rr_arbiter #(.N(NUM_REQ)) u_pick (
    .i_req   (req_valid),
    .i_ptr   (w_ptr),
    .o_grant (w_grant)
  );

  always_comb begin
    w_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) if (w_grant[i]) w_idx = IW'(i);
  end

  assign w_accept  = (r_state == S_IDLE) && |w_grant;
  assign req_ready = w_grant & {NUM_REQ{reset_n && r_state == S_IDLE}};
  assign w_sig     = req_signal[2*int'(w_idx) +: 2];
  assign w_key     = req_key[int'(w_idx)*RAM_WIDTH +: RAM_WIDTH];
  assign w_val     = req_value[int'(w_idx)*RAM_WIDTH +: RAM_WIDTH];

`ifdef KV_ARB_FIXED_PRIO_EN
  assign w_ptr = '0;
`else
  logic [IW-1:0] r_ptr;
  assign w_ptr = r_ptr;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) r_ptr <= '0;
    else if (w_accept) r_ptr <= (int'(w_idx) == NUM_REQ - 1) ? '0 : w_idx + IW'(1);
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state          <= S_IDLE;
      r_cnt            <= '0;
      r_idx            <= '0;
      r_ram_enable     <= 1'b0;
      r_write_enable   <= 1'b0;
      r_key            <= '0;
      r_value          <= '0;
      r_transact_value <= '0;
      r_signal         <= '0;
      r_transact_kind  <= 1'b0;
      r_rsp_valid      <= 1'b0;
      r_rsp_id         <= '0;
      r_rsp_data       <= '0;
      r_rsp_addr       <= '0;
      r_rsp_error      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE:
          if (w_accept) begin
            r_idx <= w_idx;
            // Reserved opcode never touches the store; store operands keep their last issued values.
            if (w_sig == OP_RSVD) begin
              r_state     <= S_RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_error <= 1'b1;
              r_rsp_id    <= w_idx;
              r_rsp_data  <= '0;
              r_rsp_addr  <= '0;
            end else begin
              r_state          <= S_ISSUE;
              r_ram_enable     <= 1'b1;
              r_write_enable   <= w_sig != OP_SEARCH;
              r_signal         <= w_sig;
              r_key            <= w_key;
              r_value          <= w_val;
              r_transact_value <= w_val;
              r_transact_kind  <= req_transact_kind[w_idx];
            end
          end
        S_ISSUE: begin
          r_state <= S_WAIT;
          r_cnt   <= CW'(OP_LATENCY);
        end
        S_WAIT:
          if (r_cnt == CW'(1)) begin
            r_state        <= S_RESP;
            r_cnt          <= '0;
            r_ram_enable   <= 1'b0;
            r_write_enable <= 1'b0;
            r_rsp_valid    <= 1'b1;
            r_rsp_error    <= 1'b0;
            r_rsp_id       <= r_idx;
            r_rsp_data     <= updated_value;
            r_rsp_addr     <= value_addr;
          end else r_cnt <= r_cnt - CW'(1);
        S_RESP:
          if (rsp_ready) begin
            r_state     <= S_IDLE;
            r_rsp_valid <= 1'b0;
          end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ram_enable     = r_ram_enable;
  assign write_enable   = r_write_enable;
  assign key            = r_key;
  assign value          = r_value;
  assign transact_value = r_transact_value;
  assign signal         = r_signal;
  assign transact_kind  = r_transact_kind;
  assign rsp_valid      = r_rsp_valid;
  assign rsp_id         = r_rsp_id;
  assign rsp_data       = r_rsp_data;
  assign rsp_addr       = r_rsp_addr;
  assign rsp_error      = r_rsp_error;
  assign busy           = r_state != S_IDLE;
endmodule

// File: tb/tb_kv_request_arbiter.sv
// tb_kv_request_arbiter: randomized self-checking bench with a behavioural store and arbitration model
module tb_kv_request_arbiter;
  localparam int N = 4, W = 32, L = 8;
  logic clock = 1'b0, reset_n = 1'b0, rsp_ready = 1'b0;
  logic [N-1:0] req_valid = '0, req_ready, req_transact_kind = '0;
  logic [2*N-1:0] req_signal = '0;
  logic [W*N-1:0] req_key = '0, req_value = '0;
  logic ram_enable, write_enable, transact_kind, rsp_valid, rsp_error, busy;
  logic [W-1:0] key, value, transact_value, rsp_data, rsp_addr;
  logic [W-1:0] updated_value = '0, value_addr = '0, st_data = '0, st_addr = '0;
  logic [1:0] signal, rsp_id;
  logic [W-1:0] mem [logic [W-1:0]];
  int total = 0, bad = 0, cyc = 0, en_cnt = 0, last_g = N - 1;

  kv_request_arbiter #(.RAM_WIDTH(W), .NUM_REQ(N), .OP_LATENCY(L)) dut (
    .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_signal(req_signal), .req_key(req_key), .req_value(req_value),
    .req_transact_kind(req_transact_kind), .ram_enable(ram_enable), .write_enable(write_enable),
    .key(key), .value(value), .transact_value(transact_value), .signal(signal),
    .transact_kind(transact_kind), .updated_value(updated_value), .value_addr(value_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_addr(rsp_addr), .rsp_error(rsp_error), .busy(busy)
  );

  always #5 clock = ~clock;
  initial forever begin @(posedge clock); cyc++; end

  // Store model: the result is only valid during the last cycle of the latency window, junk otherwise.
  initial forever begin
    @(negedge clock);
    en_cnt = ram_enable ? en_cnt + 1 : 0;
    if (en_cnt == L + 1) begin updated_value = st_data; value_addr = st_addr; end
    else begin updated_value = $urandom; value_addr = $urandom; end
  end

  initial begin #500000; $display("FAIL watchdog timeout"); $fatal(1); end

  function automatic int exp_winner(input logic [N-1:0] m);
`ifdef KV_ARB_FIXED_PRIO_EN
    for (int i = 0; i < N; i++) if (m[i]) return i;
`else
    for (int k = 1; k <= N; k++) if (m[(last_g + k) % N]) return (last_g + k) % N;
`endif
    return -1;
  endfunction

  task automatic model_exec(input logic [1:0] op, input logic [W-1:0] k, v, input logic kd,
                            output logic [W-1:0] d, a);
    logic [W-1:0] base;
    base = mem.exists(k) ? mem[k] : '0;
    a = (k << 2) ^ 32'h1000;
    d = '0;
    if (op == 2'd0) d = base;
    else if (op == 2'd1) begin mem[k] = v; d = v; end
    else if (op == 2'd2) begin d = kd ? base - v : base + v; mem[k] = d; end
    else a = '0;
  endtask

  task automatic set_cmd(input int i, input logic [1:0] op, input logic [W-1:0] k, v, input logic kd);
    req_signal[2*i +: 2] = op;
    req_key[W*i +: W] = k;
    req_value[W*i +: W] = v;
    req_transact_kind[i] = kd;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0; req_valid = '0; rsp_ready = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1; last_g = N - 1;
  endtask

  task automatic serve(input string tag, input int g, input bit drop, input int delay);
    int a, en_seen, lat;
    bit found;
    logic [1:0] op;
    logic [W-1:0] k, v, d, ad;
    logic kd;
    found = 0;
    for (int t = 0; t < 50; t++) begin
      #1;
      if (|req_ready) begin found = 1; break; end
      @(negedge clock);
    end
    total++;
    if (!found) begin bad++; $display("FAIL %s accept: no req_ready within budget", tag); return; end
    total++;
    if (g < 0 || req_ready !== (N'(1) << g)) begin
      bad++; $display("FAIL %s grant: got %b want index %0d", tag, req_ready, g);
      return;
    end
    last_g = g;
    op = req_signal[2*g +: 2]; k = req_key[W*g +: W]; v = req_value[W*g +: W]; kd = req_transact_kind[g];
    model_exec(op, k, v, kd, d, ad);
    st_data = d; st_addr = ad; a = cyc;
    @(posedge clock); @(negedge clock);
    if (drop) req_valid[g] = 1'b0;
    #1;
    en_seen = 0;
    for (int t = 0; t < 40 && !rsp_valid; t++) begin
      total++;
      if (req_ready !== '0 || busy !== 1'b1) begin
        bad++; $display("FAIL %s in_flight: req_ready=%b busy=%b want 0/1", tag, req_ready, busy);
      end
      if (ram_enable) begin
        en_seen++;
        total++;
        if ({key, signal, write_enable, transact_kind} !== {k, op, op != 2'd0, kd}) begin
          bad++; $display("FAIL %s operands: key=%0d sig=%0d we=%b kind=%b want %0d/%0d/%b/%b",
                          tag, key, signal, write_enable, transact_kind, k, op, op != 2'd0, kd);
        end
        if (op != 2'd0) begin
          total++;
          if ((op == 2'd1 ? value : transact_value) !== v) begin
            bad++; $display("FAIL %s value: got %0d want %0d", tag, op == 2'd1 ? value : transact_value, v);
          end
        end
      end
      @(negedge clock); #1;
    end
    lat = cyc - a;
    total++;
    if (!rsp_valid || lat != (op == 2'd3 ? 1 : L + 2)) begin
      bad++; $display("FAIL %s latency: rsp_valid=%b after %0d want %0d", tag, rsp_valid, lat, op == 2'd3 ? 1 : L + 2);
    end
    total++;
    if (en_seen != (op == 2'd3 ? 0 : L + 1)) begin
      bad++; $display("FAIL %s enable_len: got %0d want %0d", tag, en_seen, op == 2'd3 ? 0 : L + 1);
    end
    total++;
    if ({rsp_id, rsp_data, rsp_addr, rsp_error} !== {2'(g), d, ad, op == 2'd3}) begin
      bad++; $display("FAIL %s response: id=%0d data=%0d addr=%0h err=%b want %0d/%0d/%0h/%b",
                      tag, rsp_id, rsp_data, rsp_addr, rsp_error, g, d, ad, op == 2'd3);
    end
    for (int j = 0; j < delay; j++) begin
      @(negedge clock); #1;
      total++;
      if ({rsp_valid, rsp_id, rsp_data, rsp_addr, rsp_error, req_ready, ram_enable} !==
          {1'b1, 2'(g), d, ad, op == 2'd3, N'(0), 1'b0}) begin
        bad++; $display("FAIL %s hold: valid=%b id=%0d data=%0d ready=%b en=%b want 1/%0d/%0d/0/0",
                        tag, rsp_valid, rsp_id, rsp_data, req_ready, ram_enable, g, d);
      end
    end
    rsp_ready = 1'b1;
    @(posedge clock); @(negedge clock);
    rsp_ready = 1'b0;
    #1;
    total++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL %s release: rsp_valid=%b busy=%b want 0/0", tag, rsp_valid, busy);
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < N; i++) set_cmd(i, 2'(i), W'(i + 7), W'(i + 9), 1'b1);
    req_valid = '1;
    @(negedge clock); #1;
    total++;
    if ({req_ready, ram_enable, write_enable, key, value, transact_value, signal, transact_kind,
         rsp_valid, rsp_id, rsp_data, rsp_addr, rsp_error, busy} !== '0) begin
      bad++; $display("FAIL reset_outputs: ready=%b en=%b busy=%b rsp_valid=%b want all 0",
                      req_ready, ram_enable, busy, rsp_valid);
    end
    do_reset();
  endtask

  task automatic test_search();
    do_reset();
    mem[32'd249] = 32'd500;
    set_cmd(0, 2'd0, 32'd249, 32'd0, 1'b0);
    req_valid = 4'b0001;
    serve("search", exp_winner(4'b0001), 1, 0);
  endtask

  task automatic test_insert();
    set_cmd(2, 2'd1, 32'd524, 32'd3423, 1'b0);
    req_valid = 4'b0100;
    serve("insert", exp_winner(4'b0100), 1, 0);
    set_cmd(2, 2'd0, 32'd524, 32'd0, 1'b0);
    req_valid = 4'b0100;
    serve("insert_readback", exp_winner(4'b0100), 1, 0);
  endtask

  task automatic test_rr_order();
    do_reset();
    for (int i = 0; i < N; i++) set_cmd(i, 2'd0, W'(300 + i), 32'd0, 1'b0);
    req_valid = '1;
    for (int i = 0; i < 5; i++) serve("order", exp_winner('1), 0, 0);
    req_valid = '0;
  endtask

  task automatic test_backpressure();
    set_cmd(1, 2'd2, 32'd524, 32'd23, 1'b1);
    req_valid = 4'b0010;
    serve("backpressure", exp_winner(4'b0010), 1, 5);
  endtask

  task automatic test_reserved();
    set_cmd(1, 2'd3, 32'd77, 32'd88, 1'b0);
    req_valid = 4'b0010;
    serve("reserved", exp_winner(4'b0010), 1, 2);
  endtask

  task automatic test_reset_midflight();
    bit quiet;
    do_reset();
    set_cmd(0, 2'd0, 32'd249, 32'd0, 1'b0);
    set_cmd(1, 2'd0, 32'd524, 32'd0, 1'b0);
    req_valid = 4'b0001;
    #1;
    total++;
    if (req_ready !== 4'b0001) begin bad++; $display("FAIL abort_accept: ready=%b want 0001", req_ready); end
    @(posedge clock); @(negedge clock);
    req_valid = '0;
    repeat (4) @(negedge clock);
    reset_n = 1'b0;
    #1;
    total++;
    if ({ram_enable, busy, rsp_valid} !== 3'b000) begin
      bad++; $display("FAIL abort_async: en=%b busy=%b rsp_valid=%b want 000", ram_enable, busy, rsp_valid);
    end
    @(negedge clock);
    reset_n = 1'b1; last_g = N - 1;
    quiet = 1;
    for (int t = 0; t < 15; t++) begin
      @(negedge clock);
      if (rsp_valid || ram_enable) quiet = 0;
    end
    total++;
    if (!quiet) begin bad++; $display("FAIL abort_silent: response or store access after aborted command"); end
    req_valid = 4'b0011;
    serve("post_reset_a", exp_winner(4'b0011), 1, 0);
    serve("post_reset_b", exp_winner(req_valid), 1, 0);
    req_valid = '0;
  endtask

  task automatic test_random();
    logic [N-1:0] m;
    for (int it = 0; it < 40; it++) begin
      for (int i = 0; i < N; i++)
        set_cmd(i, ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2)),
                W'($urandom_range(100, 107)), W'($urandom_range(0, 65535)), 1'($urandom_range(0, 1)));
      m = N'($urandom_range(1, (1 << N) - 1));
      req_valid = m;
      serve("random", exp_winner(m), 1, $urandom_range(0, 3));
      req_valid = '0;
    end
  endtask

  initial begin
    test_reset();
    test_search();
    test_insert();
    test_rr_order();
    test_backpressure();
    test_reserved();
    test_reset_midflight();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
